// File: rtl/subpel_row_sequencer.sv
// subpel_row_sequencer
//   Fetches the ROWS reference rows of one sub-pel interpolation block from
//   pixel memory, one request at a time, and presents each returned row to the
//   interpolation filters as a registered one-cycle load strobe. After the
//   last row it waits FIR_LAT cycles for the filter pipeline to drain, then
//   pulses done.
//
// Ports
//   clk       : sole clock, rising edge
//   rst       : asynchronous active-low reset
//   start     : begin one block (only honoured in IDLE)
//   abort     : cancel the current block, return to IDLE
//   row_req   : row fetch request to pixel memory
//   row_idx   : index of the row being requested (0..ROWS-1)
//   row_vld   : memory is returning row_data for row_idx
//   row_data  : fetched row contents
//   fir_row   : registered row presented to the filters
//   fir_load  : one-cycle strobe, fir_row is valid
//   v_en      : vertical-filter window complete for the loaded row
//   v_row     : vertical-filter output row index (0..7)
//   cnt       : rows loaded so far in the current block
//   busy      : high in every state except IDLE
//   done      : one-cycle pulse at block completion
module subpel_row_sequencer #(
  parameter int ROWS    = 15,
  parameter int ROW_W   = 120,
  parameter int FIR_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             row_req,
  output logic [3:0]       row_idx,
  input  logic             row_vld,
  input  logic [ROW_W-1:0] row_data,
  output logic [ROW_W-1:0] fir_row,
  output logic             fir_load,
  output logic             v_en,
  output logic [2:0]       v_row,
  output logic [3:0]       cnt,
  output logic             busy,
  output logic             done
);

  localparam int              DW         = (FIR_LAT > 1) ? $clog2(FIR_LAT) : 1;
  localparam logic [3:0]      LAST_IDX   = 4'(ROWS - 1);
  // The vertical filter needs 7 rows of history before its first output row.
  localparam logic [3:0]      TAPS       = 4'd7;
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(FIR_LAT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t             state_q,    state_d;
  logic               row_req_q,  row_req_d;
  logic [3:0]         row_idx_q,  row_idx_d;
  logic [ROW_W-1:0]   fir_row_q,  fir_row_d;
  logic               fir_load_q, fir_load_d;
  logic               v_en_q,     v_en_d;
  logic [2:0]         v_row_q,    v_row_d;
  logic [3:0]         cnt_q,      cnt_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic [DW-1:0]      drain_q,    drain_d;

  // Next-state logic. Strobe-type outputs default low every cycle; abort is
  // applied last so it overrides start and row_vld in the same cycle.
  always_comb begin
    state_d    = state_q;
    row_req_d  = row_req_q;
    row_idx_d  = row_idx_q;
    fir_row_d  = fir_row_q;
    fir_load_d = 1'b0;
    v_en_d     = 1'b0;
    v_row_d    = 3'd0;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    drain_d    = drain_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = FETCH;
          row_req_d = 1'b1;
          row_idx_d = 4'd0;
          cnt_d     = 4'd0;
          busy_d    = 1'b1;
        end
      end
      FETCH: begin
        // row_vld only counts while a request is outstanding.
        if (row_vld && row_req_q) begin
          fir_row_d  = row_data;
          fir_load_d = 1'b1;
          cnt_d      = cnt_q + 4'd1;
          if (row_idx_q >= TAPS) begin
            v_en_d  = 1'b1;
            v_row_d = 3'(row_idx_q - TAPS);
          end
          if (row_idx_q == LAST_IDX) begin
            row_req_d = 1'b0;
            drain_d   = '0;
            state_d   = DRAIN;
          end else begin
            row_idx_d = row_idx_q + 4'd1;
          end
        end
      end
      DRAIN: begin
        // DRAIN is entered on the edge that raises the last fir_load, so
        // done lands exactly FIR_LAT cycles after that strobe.
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      row_req_d  = 1'b0;
      row_idx_d  = 4'd0;
      fir_load_d = 1'b0;
      v_en_d     = 1'b0;
      v_row_d    = 3'd0;
      cnt_d      = 4'd0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  // FSM state and every output are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      row_req_q  <= 1'b0;
      row_idx_q  <= 4'd0;
      fir_row_q  <= '0;
      fir_load_q <= 1'b0;
      v_en_q     <= 1'b0;
      v_row_q    <= 3'd0;
      cnt_q      <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      row_req_q  <= row_req_d;
      row_idx_q  <= row_idx_d;
      fir_row_q  <= fir_row_d;
      fir_load_q <= fir_load_d;
      v_en_q     <= v_en_d;
      v_row_q    <= v_row_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drain_q    <= drain_d;
    end
  end

  assign row_req  = row_req_q;
  assign row_idx  = row_idx_q;
  assign fir_row  = fir_row_q;
  assign fir_load = fir_load_q;
  assign v_en     = v_en_q;
  assign v_row    = v_row_q;
  assign cnt      = cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
